// File: rtl/m_dram_responder_pkg.sv
// Shared constants for the DRAM responder: funct3 access codes, size fields
// and the arbiter FSM states.
package m_dram_responder_pkg;

    localparam int NCORES_MAX = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;

    localparam logic [1:0] SZ_BYTE = F3_LB[1:0];
    localparam logic [1:0] SZ_HALF = F3_LH[1:0];
    localparam int         UNSIGNED_BIT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/m_dram_responder_lane.sv
// Combinational lane logic: store replication/strobes and load extract with
// sign or zero extension. Sizes other than byte/half are treated as word.
module m_dram_lane
    import m_dram_responder_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] load_data
);

    logic [1:0]  lane;
    logic [31:0] shifted;
    logic        sign_fill;

    always_comb begin
        mem_wdata = wdata;
        mem_wstrb = 4'b1111;
        lane      = 2'b00;
        case (ctrl[1:0])
            SZ_BYTE: begin
                lane      = addr_lo;
                mem_wdata = {4{wdata[7:0]}};
                mem_wstrb = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                lane      = {addr_lo[1], 1'b0};
                mem_wdata = {2{wdata[15:0]}};
                mem_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    // The selected lane is moved to bit 0 before extension.
    always_comb begin
        shifted   = rdata >> {lane, 3'b000};
        sign_fill = 1'b0;
        load_data = shifted;
        case (ctrl[1:0])
            SZ_BYTE: begin
                sign_fill = ~ctrl[UNSIGNED_BIT] & shifted[7];
                load_data = {{24{sign_fill}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sign_fill = ~ctrl[UNSIGNED_BIT] & shifted[15];
                load_data = {{16{sign_fill}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m_dram_responder.sv
// Memory-side responder: captures per-core load/store pulses and serves them
// round-robin, one at a time, on a single word-wide backend port.
module m_dram_responder
    import m_dram_responder_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int MEM_AW = 30
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NCORES*32-1:0]  w_dram_addr,
    input  logic [NCORES*32-1:0]  w_dram_wdata,
    input  logic [NCORES-1:0]     w_dram_we_t,
    input  logic [NCORES-1:0]     w_dram_le,
    input  logic [NCORES*3-1:0]   w_dram_ctrl,
    output logic [NCORES*32-1:0]  w_dram_odata,
    output logic [NCORES-1:0]     w_dram_busy,
    output logic [NCORES_MAX-1:0] w_grant,
    output logic                  w_mem_req,
    output logic                  w_mem_we,
    output logic [MEM_AW-1:0]     w_mem_addr,
    output logic [31:0]           w_mem_wdata,
    output logic [3:0]            w_mem_wstrb,
    input  logic                  w_mem_ack,
    input  logic [31:0]           w_mem_rdata
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    state_t            state, state_next;
    logic [NCORES-1:0] pending;
    logic [NCORES-1:0] cap_store;
    logic [31:0]       cap_addr  [NCORES];
    logic [31:0]       cap_wdata [NCORES];
    logic [2:0]        cap_ctrl  [NCORES];

    logic [IW-1:0] rr_ptr, cur_idx, pick_idx, sel_idx;
    logic [IW:0]   scan_idx;
    logic          pick_valid, load_mem, finish;
    logic [31:0]   lane_wdata, lane_load;
    logic [3:0]    lane_wstrb;

    assign w_dram_busy = pending;

    // Scanning downward lets the smallest offset from rr_ptr win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan_idx >= (IW+1)'(NCORES))
                scan_idx = scan_idx - (IW+1)'(NCORES);
            if (pending[scan_idx[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx[IW-1:0];
            end
        end
    end

    assign sel_idx = (state == ST_REQ) ? cur_idx : pick_idx;

    m_dram_lane u_lane (
        .ctrl      (cap_ctrl[sel_idx]),
        .addr_lo   (cap_addr[sel_idx][1:0]),
        .wdata     (cap_wdata[sel_idx]),
        .rdata     (w_mem_rdata),
        .mem_wdata (lane_wdata),
        .mem_wstrb (lane_wstrb),
        .load_data (lane_load)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_mem   = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: if (pick_valid) begin
                state_next = ST_REQ;
                load_mem   = 1'b1;
            end
            ST_REQ: if (w_mem_ack) begin
                state_next = ST_IDLE;
                finish     = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A core's captured fields stay frozen until its transaction completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending   <= '0;
            cap_store <= '0;
            for (int c = 0; c < NCORES; c++) begin
                cap_addr[c]  <= '0;
                cap_wdata[c] <= '0;
                cap_ctrl[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCORES; c++) begin
                if (pending[c]) begin
                    if (finish && cur_idx == IW'(c))
                        pending[c] <= 1'b0;
                end else if (w_dram_we_t[c] | w_dram_le[c]) begin
                    pending[c]   <= 1'b1;
                    cap_store[c] <= w_dram_we_t[c];
                    cap_addr[c]  <= w_dram_addr[c*32 +: 32];
                    cap_wdata[c] <= w_dram_wdata[c*32 +: 32];
                    cap_ctrl[c]  <= w_dram_ctrl[c*3 +: 3];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_mem_req    <= 1'b0;
            w_mem_we     <= 1'b0;
            w_mem_addr   <= '0;
            w_mem_wdata  <= '0;
            w_mem_wstrb  <= '0;
            w_grant      <= '0;
            rr_ptr       <= '0;
            cur_idx      <= '0;
            w_dram_odata <= '0;
        end else begin
            if (load_mem) begin
                w_mem_req   <= 1'b1;
                w_mem_we    <= cap_store[pick_idx];
                w_mem_addr  <= cap_addr[pick_idx][MEM_AW+1:2];
                w_mem_wdata <= lane_wdata;
                w_mem_wstrb <= cap_store[pick_idx] ? lane_wstrb : 4'b0000;
                w_grant     <= NCORES_MAX'(1) << pick_idx;
                cur_idx     <= pick_idx;
            end
            if (finish) begin
                w_mem_req <= 1'b0;
                w_grant   <= '0;
                rr_ptr    <= (cur_idx == IW'(NCORES - 1)) ? '0 : cur_idx + 1'b1;
                if (!cap_store[cur_idx])
                    w_dram_odata[{cur_idx, 5'b00000} +: 32] <= lane_load;
            end
        end
    end

endmodule

// File: tb/tb_m_dram_responder.sv
// Directed bench for m_dram_responder: lane handling, latency, round-robin
// fairness, ignored duplicate pulses and reset during a transaction.
module tb_m_dram_responder;

    localparam int NCORES = 2;
    localparam int MEM_AW = 30;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NCORES*32-1:0] w_dram_addr;
    logic [NCORES*32-1:0] w_dram_wdata;
    logic [NCORES-1:0]    w_dram_we_t;
    logic [NCORES-1:0]    w_dram_le;
    logic [NCORES*3-1:0]  w_dram_ctrl;
    logic [NCORES*32-1:0] w_dram_odata;
    logic [NCORES-1:0]    w_dram_busy;
    logic [31:0]          w_grant;
    logic                 w_mem_req;
    logic                 w_mem_we;
    logic [MEM_AW-1:0]    w_mem_addr;
    logic [31:0]          w_mem_wdata;
    logic [3:0]           w_mem_wstrb;
    logic                 w_mem_ack;
    logic [31:0]          w_mem_rdata;

    int checksTotal  = 0;
    int checksPassed = 0;
    int busyCnt;
    int waitCnt;
    int reqCnt;

    m_dram_responder #(.NCORES(NCORES), .MEM_AW(MEM_AW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .w_dram_addr  (w_dram_addr),
        .w_dram_wdata (w_dram_wdata),
        .w_dram_we_t  (w_dram_we_t),
        .w_dram_le    (w_dram_le),
        .w_dram_ctrl  (w_dram_ctrl),
        .w_dram_odata (w_dram_odata),
        .w_dram_busy  (w_dram_busy),
        .w_grant      (w_grant),
        .w_mem_req    (w_mem_req),
        .w_mem_we     (w_mem_we),
        .w_mem_addr   (w_mem_addr),
        .w_mem_wdata  (w_mem_wdata),
        .w_mem_wstrb  (w_mem_wstrb),
        .w_mem_ack    (w_mem_ack),
        .w_mem_rdata  (w_mem_rdata)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checksTotal++;
        if (got === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input int core, input bit isStore, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [2:0] ctrl);
        w_dram_addr[core*32 +: 32]  = addr;
        w_dram_wdata[core*32 +: 32] = data;
        w_dram_ctrl[core*3 +: 3]    = ctrl;
        if (isStore) w_dram_we_t[core] = 1'b1;
        else         w_dram_le[core]   = 1'b1;
    endtask

    task automatic clearStimulus();
        w_dram_we_t = '0;
        w_dram_le   = '0;
    endtask

    task automatic waitReq(input string tag, output int cycles);
        cycles = 0;
        for (int g = 0; g < 16 && !w_mem_req; g++) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_req"}, 32'(w_mem_req), 32'd1);
    endtask

    task automatic ackWith(input logic [31:0] rdata);
        w_mem_ack   = 1'b1;
        w_mem_rdata = rdata;
        tick();
        w_mem_ack   = 1'b0;
        w_mem_rdata = '0;
    endtask

    task automatic runTxn(input string tag, input int core, input bit isStore,
                          input logic [31:0] addr, input logic [31:0] data, input logic [2:0] ctrl,
                          input logic [31:0] rdata, input int ackDelay,
                          input logic [29:0] expAddr, input logic [31:0] expWdata,
                          input logic [3:0] expStrb, output int busyCycles);
        applyStimulus(core, isStore, addr, data, ctrl);
        tick();
        clearStimulus();
        busyCycles = 0;
        for (int g = 0; g < 16 && !w_mem_req; g++) begin
            busyCycles += int'(w_dram_busy[core]);
            tick();
        end
        checkOutput({tag, "_req"}, 32'(w_mem_req), 32'd1);
        for (int k = 0; k < ackDelay; k++) begin
            busyCycles += int'(w_dram_busy[core]);
            tick();
        end
        busyCycles += int'(w_dram_busy[core]);
        checkOutput({tag, "_addr"}, 32'(w_mem_addr), 32'(expAddr));
        checkOutput({tag, "_we"}, 32'(w_mem_we), 32'(isStore));
        checkOutput({tag, "_wstrb"}, 32'(w_mem_wstrb), 32'(expStrb));
        checkOutput({tag, "_grant"}, w_grant, 32'd1 << core);
        if (isStore) checkOutput({tag, "_wdata"}, w_mem_wdata, expWdata);
        ackWith(rdata);
        checkOutput({tag, "_busyFall"}, 32'(w_dram_busy[core]), 32'd0);
        checkOutput({tag, "_reqFall"}, 32'(w_mem_req), 32'd0);
        checkOutput({tag, "_grantClr"}, w_grant, 32'd0);
    endtask

    initial begin
        RST          = 1'b1;
        w_dram_addr  = '0;
        w_dram_wdata = '0;
        w_dram_we_t  = '0;
        w_dram_le    = '0;
        w_dram_ctrl  = '0;
        w_mem_ack    = 1'b0;
        w_mem_rdata  = '0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(w_dram_busy), 32'd0);
        checkOutput("rst_grant", w_grant, 32'd0);
        checkOutput("rst_req", 32'(w_mem_req), 32'd0);
        checkOutput("rst_odata0", w_dram_odata[31:0], 32'd0);
        checkOutput("rst_wstrb", 32'(w_mem_wstrb), 32'd0);
        RST = 1'b0;
        tick();

        runTxn("sw", 0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 32'h0, 2,
               30'h2000_0001, 32'hDEAD_BEEF, 4'b1111, busyCnt);
        checkOutput("sw_busyCycles", 32'(busyCnt), 32'd4);

        runTxn("lb", 0, 1'b0, 32'h8000_0007, 32'h0, 3'b000, 32'hDEAD_BEEF, 0,
               30'h2000_0001, 32'h0, 4'b0000, busyCnt);
        checkOutput("lb_odata", w_dram_odata[31:0], 32'hFFFF_FFDE);
        checkOutput("lb_minLatency", 32'(busyCnt), 32'd2);

        runTxn("lbu", 0, 1'b0, 32'h8000_0007, 32'h0, 3'b100, 32'hDEAD_BEEF, 1,
               30'h2000_0001, 32'h0, 4'b0000, busyCnt);
        checkOutput("lbu_odata", w_dram_odata[31:0], 32'h0000_00DE);

        runTxn("lh", 0, 1'b0, 32'h8000_0006, 32'h0, 3'b001, 32'hDEAD_BEEF, 0,
               30'h2000_0001, 32'h0, 4'b0000, busyCnt);
        checkOutput("lh_odata", w_dram_odata[31:0], 32'hFFFF_DEAD);

        runTxn("lhu", 0, 1'b0, 32'h8000_0005, 32'h0, 3'b101, 32'hDEAD_BEEF, 0,
               30'h2000_0001, 32'h0, 4'b0000, busyCnt);
        checkOutput("lhu_odata", w_dram_odata[31:0], 32'h0000_BEEF);

        runTxn("sb", 0, 1'b1, 32'h8000_0001, 32'h0000_0055, 3'b000, 32'h0, 0,
               30'h2000_0000, 32'h5555_5555, 4'b0010, busyCnt);
        runTxn("sh", 0, 1'b1, 32'h8000_0003, 32'h0000_1234, 3'b001, 32'h0, 0,
               30'h2000_0000, 32'h1234_1234, 4'b1100, busyCnt);
        checkOutput("store_keepsOdata", w_dram_odata[31:0], 32'h0000_BEEF);

        runTxn("lw1", 1, 1'b0, 32'h8000_000B, 32'h0, 3'b010, 32'h1234_5678, 1,
               30'h2000_0002, 32'h0, 4'b0000, busyCnt);
        checkOutput("lw1_odata1", w_dram_odata[63:32], 32'h1234_5678);
        checkOutput("lw1_odata0Held", w_dram_odata[31:0], 32'h0000_BEEF);

        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, 3'b010);
            applyStimulus(1, 1'b0, 32'h8000_0010, 32'h0, 3'b010);
            tick();
            clearStimulus();
            for (int k = 0; k < 2; k++) begin
                waitReq($sformatf("rr%0d_%0d", r, k), waitCnt);
                if (k == 1) checkOutput($sformatf("rr%0d_gap", r), 32'(waitCnt), 32'd1);
                checkOutput($sformatf("rr%0d_%0d_grant", r, k), w_grant, 32'd1 << k);
                ackWith(32'hA000_0000 | (r << 4) | k);
                checkOutput($sformatf("rr%0d_%0d_reqFall", r, k), 32'(w_mem_req), 32'd0);
                checkOutput($sformatf("rr%0d_%0d_odata", r, k), w_dram_odata[k*32 +: 32],
                            32'hA000_0000 | (r << 4) | k);
            end
        end

        applyStimulus(1, 1'b0, 32'h8000_0020, 32'h0, 3'b010);
        tick();
        clearStimulus();
        tick();
        applyStimulus(1, 1'b1, 32'h8000_0030, 32'hCAFE_F00D, 3'b010);
        tick();
        clearStimulus();
        waitReq("dup", waitCnt);
        checkOutput("dup_addr", 32'(w_mem_addr), 32'h2000_0008);
        checkOutput("dup_we", 32'(w_mem_we), 32'd0);
        ackWith(32'h7777_0001);
        checkOutput("dup_odata1", w_dram_odata[63:32], 32'h7777_0001);
        reqCnt = 0;
        for (int g = 0; g < 6; g++) begin
            tick();
            reqCnt += int'(w_mem_req);
        end
        checkOutput("dup_noSecondTxn", 32'(reqCnt), 32'd0);
        checkOutput("dup_busyIdle", 32'(w_dram_busy), 32'd0);

        applyStimulus(0, 1'b0, 32'h8000_0040, 32'h0, 3'b010);
        tick();
        clearStimulus();
        waitReq("rstMid", waitCnt);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ackWith(32'hFFFF_FFFF);
        checkOutput("rstMid_odata0", w_dram_odata[31:0], 32'd0);
        checkOutput("rstMid_odata1", w_dram_odata[63:32], 32'd0);
        checkOutput("rstMid_busy", 32'(w_dram_busy), 32'd0);
        checkOutput("rstMid_grant", w_grant, 32'd0);
        checkOutput("rstMid_req", 32'(w_mem_req), 32'd0);
        tick();
        tick();
        checkOutput("rstMid_staysIdle", 32'(w_mem_req), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
